// File: rtl/block_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : block_adder_ctrl
// Description : Sequencer for the 9-lane block adder. Pairs one branch-A beat
//               with one branch-B beat, enables the adder output register,
//               tracks that register as a 1-deep valid/ready stage, counts a
//               programmed number of words per tile and pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module block_adder_ctrl #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [CW-1:0] i_num_words,
  input  logic          i_abort,
  input  logic          i_a_valid,
  output logic          o_a_ready,
  input  logic          i_b_valid,
  output logic          o_b_ready,
  output logic          o_add_en,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [CW-1:0] c_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        r_state;
  logic [CW-1:0] r_num_words;
  logic [CW-1:0] r_in_cnt;
  logic [CW-1:0] r_out_cnt;
  logic          r_out_valid;
  logic          r_done;

  logic          w_slot_free;
  logic          w_fire;
  logic          w_out_hs;
  logic          w_last_in;
  logic          w_last_out;

  // The output register can take a new sum if it is empty or being drained
  // this very cycle; A and B are only ever consumed together.
  assign w_slot_free = !r_out_valid || i_out_ready;
  assign w_fire      = (r_state == S_RUN) && i_a_valid && i_b_valid && w_slot_free;
  assign w_out_hs    = r_out_valid && i_out_ready;
  assign w_last_in   = (r_in_cnt  == (r_num_words - c_ONE));
  assign w_last_out  = (r_out_cnt == (r_num_words - c_ONE));

  assign o_a_ready   = w_fire;
  assign o_b_ready   = w_fire;
  assign o_add_en    = w_fire;
  assign o_out_valid = r_out_valid;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;

  // Tile sequencing, output-stage occupancy and word counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_num_words <= '0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_abort) begin
        // Abandon wins over everything, including a simultaneous start.
        r_state     <= S_IDLE;
        r_out_valid <= 1'b0;
        r_in_cnt    <= '0;
        r_out_cnt   <= '0;
      end else begin
        // A new sum overrides a drain in the same cycle (back-to-back flow).
        if (w_fire) begin
          r_out_valid <= 1'b1;
        end else if (i_out_ready) begin
          r_out_valid <= 1'b0;
        end

        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_num_words <= i_num_words;
              r_in_cnt    <= '0;
              r_out_cnt   <= '0;
              if (i_num_words == '0) begin
                r_done <= 1'b1;
              end else begin
                r_state <= S_RUN;
              end
            end
          end
          S_RUN, S_DRAIN: begin
            if (w_fire) begin
              r_in_cnt <= r_in_cnt + c_ONE;
              if (w_last_in) begin
                r_state <= S_DRAIN;
              end
            end
            if (w_out_hs) begin
              r_out_cnt <= r_out_cnt + c_ONE;
              if (w_last_out) begin
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
